gpio_irq_npins: RTL and testbench



---
 rtl/gpio_pkg.sv | 31 +++
 rtl/gpio_in_filter.sv | 68 ++++++
 rtl/gpio_irq_npins.sv | 125 ++++++++++++
 tb/tb_gpio_irq_npins.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_pkg
//  Description : Shared constants and helpers for the gpio_irq_npins port:
//                register address map, address width and filter counter
//                width calculation.
//  Revision    : 1.0 - initial release
// ============================================================================
package gpio_pkg;

  // Register bus address width
  localparam int ADDR_W = 4;

  // Register address map
  localparam logic [ADDR_W-1:0] ADDR_DATA_OUT   = 4'd0;
  localparam logic [ADDR_W-1:0] ADDR_DIR        = 4'd1;
  localparam logic [ADDR_W-1:0] ADDR_DATA_IN    = 4'd2;
  localparam logic [ADDR_W-1:0] ADDR_SET        = 4'd3;
  localparam logic [ADDR_W-1:0] ADDR_CLR        = 4'd4;
  localparam logic [ADDR_W-1:0] ADDR_TGL        = 4'd5;
  localparam logic [ADDR_W-1:0] ADDR_RISE_EN    = 4'd6;
  localparam logic [ADDR_W-1:0] ADDR_FALL_EN    = 4'd7;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_STATUS = 4'd8;

  // Counter must hold values 0..FILTER_CYCLES
  function automatic int filter_cnt_width(input int filter_cycles);
    return $clog2(filter_cycles + 1);
  endfunction

endpackage : gpio_pkg
`default_nettype wire

// File: rtl/gpio_in_filter.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_in_filter
//  Description : One GPIO input pin: multi-flop synchroniser followed by a
//                stability filter. Emits single-cycle rise/fall indications
//                that are asserted during the cycle whose closing edge
//                updates the filtered value.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_in_filter
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pad,
  output logic filtered,
  output logic rise,
  output logic fall
);

  localparam int CW = filter_cnt_width(FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   filt_q;
  logic                   synced;
  logic                   mismatch;
  logic                   update;

  assign synced   = sync_q[SYNC_STAGES-1];
  assign mismatch = (synced != filt_q);
  // The FILTER_CYCLES-th consecutive mismatching sample commits the new value
  assign update   = mismatch && (cnt_q == CNT_LAST);

  assign filtered = filt_q;
  assign rise     = update &&  synced;
  assign fall     = update && !synced;

  // Synchroniser chain: pad enters at bit 0, synchronised value leaves at the top
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
    end
  end

  // Stability filter: count mismatching samples, adopt new value once enough seen
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else if (!mismatch) begin
      cnt_q  <= '0;
    end else if (update) begin
      cnt_q  <= '0;
      filt_q <= synced;
    end else begin
      cnt_q  <= cnt_q + CW'(1);
    end
  end

endmodule : gpio_in_filter
`default_nettype wire

// File: rtl/gpio_irq_npins.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_irq_npins
//  Description : N-pin GPIO port with per-pin direction, atomic set/clear/
//                toggle of the output register, synchronised and glitch-
//                filtered inputs, rise/fall edge detection, sticky W1C
//                interrupt status and a single interrupt output.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_irq_npins
  import gpio_pkg::*;
#(
  parameter int N_PINS        = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [N_PINS-1:0] wdata,
  output logic [N_PINS-1:0] rdata,
  input  logic [N_PINS-1:0] gpio_pins,
  output logic [N_PINS-1:0] gpio_pins_out,
  output logic [N_PINS-1:0] gpio_oe,
  output logic              irq
);

  logic [N_PINS-1:0] data_out_q;
  logic [N_PINS-1:0] dir_q;
  logic [N_PINS-1:0] rise_en_q;
  logic [N_PINS-1:0] fall_en_q;
  logic [N_PINS-1:0] status_q;
  logic [N_PINS-1:0] rdata_q;

  logic [N_PINS-1:0] data_in;
  logic [N_PINS-1:0] rise_vec;
  logic [N_PINS-1:0] fall_vec;
  logic [N_PINS-1:0] event_vec;
  logic [N_PINS-1:0] w1c_vec;
  logic [N_PINS-1:0] rd_mux;

  // Per-pin input conditioning
  generate
    for (genvar i = 0; i < N_PINS; i++) begin : g_pin
      gpio_in_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
      ) u_in_filter (
        .clk      (clk),
        .reset    (reset),
        .pad      (gpio_pins[i]),
        .filtered (data_in[i]),
        .rise     (rise_vec[i]),
        .fall     (fall_vec[i])
      );
    end
  endgenerate

  // Control registers written from the bus; SET/CLR/TGL modify DATA_OUT atomically
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_q <= '0;
      dir_q      <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
    end else if (wr_en) begin
      case (addr)
        ADDR_DATA_OUT: data_out_q <= wdata;
        ADDR_DIR:      dir_q      <= wdata;
        ADDR_SET:      data_out_q <= data_out_q | wdata;
        ADDR_CLR:      data_out_q <= data_out_q & ~wdata;
        ADDR_TGL:      data_out_q <= data_out_q ^ wdata;
        ADDR_RISE_EN:  rise_en_q  <= wdata;
        ADDR_FALL_EN:  fall_en_q  <= wdata;
        default: ;
      endcase
    end
  end

  // Enabled edges from the filters; uses enables as they stand before any same-cycle write
  assign event_vec = (rise_vec & rise_en_q) | (fall_vec & fall_en_q);
  assign w1c_vec   = (wr_en && (addr == ADDR_IRQ_STATUS)) ? wdata : '0;

  // Sticky status: clear applied first so a simultaneous new event keeps the bit set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      status_q <= '0;
    end else begin
      status_q <= (status_q & ~w1c_vec) | event_vec;
    end
  end

  // Read mux reflects register contents before any write in the same cycle
  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_DATA_OUT:   rd_mux = data_out_q;
      ADDR_DIR:        rd_mux = dir_q;
      ADDR_DATA_IN:    rd_mux = data_in;
      ADDR_RISE_EN:    rd_mux = rise_en_q;
      ADDR_FALL_EN:    rd_mux = fall_en_q;
      ADDR_IRQ_STATUS: rd_mux = status_q;
      default:         rd_mux = '0;
    endcase
  end

  // Registered read data, held between reads
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      rdata_q <= rd_mux;
    end
  end

  assign rdata         = rdata_q;
  assign gpio_pins_out = data_out_q;
  assign gpio_oe       = dir_q;
  // Interrupt derives only from status flops, never directly from the pads
  assign irq           = |status_q;

endmodule : gpio_irq_npins
`default_nettype wire

// File: tb/tb_gpio_irq_npins.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpio_irq_npins
//  Description : Directed self-checking bench for gpio_irq_npins at default
//                parameters (16 pins, 2 sync stages, 4 filter cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_irq_npins;

  localparam int N = 16;

  logic         clk;
  logic         reset;
  logic         wr_en;
  logic         rd_en;
  logic [3:0]   addr;
  logic [N-1:0] wdata;
  logic [N-1:0] rdata;
  logic [N-1:0] gpio_pins;
  logic [N-1:0] gpio_pins_out;
  logic [N-1:0] gpio_oe;
  logic         irq;

  int checks = 0;
  int errors = 0;

  gpio_irq_npins #(
    .N_PINS        (N),
    .SYNC_STAGES   (2),
    .FILTER_CYCLES (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .rd_en         (rd_en),
    .addr          (addr),
    .wdata         (wdata),
    .rdata         (rdata),
    .gpio_pins     (gpio_pins),
    .gpio_pins_out (gpio_pins_out),
    .gpio_oe       (gpio_oe),
    .irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reg_wr(input logic [3:0] a, input logic [N-1:0] d);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    tick();
    wr_en = 1'b0;
    wdata = '0;
  endtask

  task automatic reg_rd(input logic [3:0] a, output logic [N-1:0] d);
    rd_en = 1'b1;
    addr  = a;
    tick();
    rd_en = 1'b0;
    d     = rdata;
  endtask

  logic [N-1:0] rv;

  initial begin
    reset     = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    addr      = '0;
    wdata     = '0;
    gpio_pins = '0;
    tick(3);
    #2 reset = 1'b1;
    tick();

    // ---------------- Reset state ----------------
    check("rst_oe",       gpio_oe,       16'h0000);
    check("rst_pins_out", gpio_pins_out, 16'h0000);
    check("rst_irq",      irq,           1'b0);
    check("rst_rdata",    rdata,         16'h0000);
    for (int a = 0; a < 16; a++) begin
      reg_rd(4'(a), rv);
      check($sformatf("rst_read_a%0d", a), rv, 16'h0000);
    end

    // ---------------- Output register and atomic ops ----------------
    reg_wr(4'd1, 16'hF0F0);
    reg_wr(4'd0, 16'h00FF);
    reg_wr(4'd3, 16'h0F00);   // -> 0FFF
    reg_wr(4'd4, 16'h000F);   // -> 0FF0
    reg_wr(4'd5, 16'hFFFF);   // -> F00F
    check("pins_out_ops", gpio_pins_out, 16'hF00F);
    check("oe_dir",       gpio_oe,       16'hF0F0);
    reg_rd(4'd0, rv);
    check("rd_data_out",  rv, 16'hF00F);
    reg_rd(4'd1, rv);
    check("rd_dir",       rv, 16'hF0F0);
    reg_rd(4'd3, rv);
    check("rd_set_zero",  rv, 16'h0000);
    reg_rd(4'd5, rv);
    check("rd_tgl_zero",  rv, 16'h0000);
    // Same-cycle read and write returns the pre-write value
    wr_en = 1'b1; rd_en = 1'b1; addr = 4'd0; wdata = 16'h1234;
    tick();
    wr_en = 1'b0; rd_en = 1'b0; wdata = '0;
    check("rw_same_cycle_rdata", rdata,         16'hF00F);
    check("rw_same_cycle_out",   gpio_pins_out, 16'h1234);

    // ---------------- Rising edge on pin 0, latency 6 edges ----------------
    reg_wr(4'd6, 16'h0001);
    gpio_pins[0] = 1'b1;      // stable before edge E1
    tick(5);                  // E1..E5
    check("rise_irq_before_e6", irq, 1'b0);
    tick();                   // E6
    check("rise_irq_at_e6", irq, 1'b1);
    reg_rd(4'd2, rv);
    check("rise_data_in", rv, 16'h0001);
    reg_rd(4'd8, rv);
    check("rise_status",  rv, 16'h0001);
    reg_wr(4'd8, 16'h0001);
    check("w1c_irq_clear", irq, 1'b0);

    // ---------------- 3-cycle glitch on pin 3 is rejected ----------------
    reg_wr(4'd6, 16'h0008);
    reg_wr(4'd7, 16'h0008);
    gpio_pins[3] = 1'b1;
    tick(3);
    gpio_pins[3] = 1'b0;
    tick(10);
    reg_rd(4'd2, rv);
    check("glitch_data_in", rv, 16'h0001);
    reg_rd(4'd8, rv);
    check("glitch_status",  rv, 16'h0000);
    check("glitch_irq",     irq, 1'b0);

    // ---------------- Pin 2 fall with W1C in the update cycle ----------------
    reg_wr(4'd7, 16'h0004);
    gpio_pins[2] = 1'b1;      // rise on pin 2 is not enabled
    tick(10);
    check("pin2_high_no_irq", irq, 1'b0);
    reg_rd(4'd2, rv);
    check("pin2_high_data_in", rv, 16'h0005);
    gpio_pins[2] = 1'b0;      // stable before E1
    tick(5);                  // E1..E5
    check("fall_irq_before_e6", irq, 1'b0);
    wr_en = 1'b1; addr = 4'd8; wdata = 16'h0004;
    tick();                   // E6: filtered update and W1C coincide
    wr_en = 1'b0; wdata = '0;
    check("fall_set_wins_irq", irq, 1'b1);
    reg_rd(4'd8, rv);
    check("fall_set_wins_status", rv, 16'h0004);
    reg_wr(4'd7, 16'h0000);   // disabling the edge keeps the sticky bit
    reg_rd(4'd8, rv);
    check("status_after_en_clear", rv, 16'h0004);

    // ---------------- Asynchronous reset mid-filter ----------------
    reg_wr(4'd0, 16'hAAAA);
    check("pre_reset_pins_out", gpio_pins_out, 16'hAAAA);
    gpio_pins[5] = 1'b1;
    tick(3);                  // pin 5 filter part-way through
    #2 reset = 1'b0;          // mid-cycle, away from any edge
    #1;
    check("async_rst_pins_out", gpio_pins_out, 16'h0000);
    check("async_rst_oe",       gpio_oe,       16'h0000);
    check("async_rst_irq",      irq,           1'b0);
    check("async_rst_rdata",    rdata,         16'h0000);
    gpio_pins = '0;
    tick(2);
    #2 reset = 1'b1;
    tick(12);
    check("post_rst_irq", irq, 1'b0);
    reg_rd(4'd2, rv);
    check("post_rst_data_in", rv, 16'h0000);
    reg_rd(4'd8, rv);
    check("post_rst_status",  rv, 16'h0000);
    reg_rd(4'd0, rv);
    check("post_rst_data_out", rv, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_gpio_irq_npins
`default_nettype wire
